// File: rtl/rr_arb8_ctrl_if.sv
// Request/grant bundle between the requesters and the 8-way round-robin arbiter.
// The master side drives enable and requests, and the slave side returns the grant.
interface rr_arb8_ctrl_if;
    logic       en;
    logic [7:0] req;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       gnt_vld;

    modport master (output en, req, input sel, gnt, gnt_vld);
    modport slave  (input en, req, output sel, gnt, gnt_vld);
endinterface

// File: rtl/rr_arb8_ctrl.sv
// 8-way round-robin arbiter for a shared 3-to-8 decoded resource.
// A grant is held until release, disable or MAX_HOLD cycles, and every grant is followed by one idle cycle.
module rr_arb8_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb8_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t      state, state_nxt;
    logic [2:0]  ptr, ptr_nxt;
    logic [7:0]  hcnt, hcnt_nxt;
    logic [2:0]  sel_q, sel_nxt;
    logic [7:0]  gnt_q, gnt_nxt;
    logic        vld_q, vld_nxt;

    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  winner;
    logic        found;

    // Rotate the requests so that bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin : pick_winner
        req_dbl = {bus.req, bus.req};
        req_rot = 8'(req_dbl >> ptr);
        winner  = ptr;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req_rot[i]) begin
                winner = ptr + 3'(i);
                found  = 1'b1;
            end
        end
    end

    // NOTE: every variable gets a default before the case so that no path leaves it unassigned, which would infer a latch.
    always_comb begin : next_state
        state_nxt = state;
        ptr_nxt   = ptr;
        hcnt_nxt  = hcnt;
        sel_nxt   = sel_q;
        gnt_nxt   = gnt_q;
        vld_nxt   = vld_q;
        case (state)
            IDLE: begin
                if (bus.en && (bus.req != 8'h00)) begin
                    state_nxt = GRANT;
                    hcnt_nxt  = 8'd1;
                    sel_nxt   = winner;
                    gnt_nxt   = 8'b1 << winner;
                    vld_nxt   = 1'b1;
                end
            end
            GRANT: begin
                // All release causes merge into one transition, so coincident causes behave like any single one.
                if (!bus.req[sel_q] || !bus.en || (hcnt == HOLD_LIMIT)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = sel_q + 3'd1;
                    hcnt_nxt  = 8'd0;
                    gnt_nxt   = 8'h00;
                    vld_nxt   = 1'b0;
                end else begin
                    hcnt_nxt = hcnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every flop samples the pre-edge values.
    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd0;
            hcnt  <= 8'd0;
            sel_q <= 3'd0;
            gnt_q <= 8'h00;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            hcnt  <= hcnt_nxt;
            sel_q <= sel_nxt;
            gnt_q <= gnt_nxt;
            vld_q <= vld_nxt;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.gnt     = gnt_q;
    assign bus.gnt_vld = vld_q;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Scoreboard bench for rr_arb8_ctrl.
// Two instances (hold limit 4 and hold limit 1) share the same stimulus, and each has its own reference model.
module tb_rr_arb8_ctrl;

    localparam int HOLD_A = 4;
    localparam int HOLD_B = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arb8_ctrl_if bus_a ();
    rr_arb8_ctrl_if bus_b ();

    rr_arb8_ctrl #(.MAX_HOLD(HOLD_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    rr_arb8_ctrl #(.MAX_HOLD(HOLD_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       vld;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: whether a grant is active, its owner, how long it has been held,
    // where the next search starts, and the last reported index.
    bit m_busy  [2];
    int m_owner [2];
    int m_held  [2];
    int m_start [2];
    int m_sel   [2];
    int m_limit [2] = '{HOLD_A, HOLD_B};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input bit r, input bit e, input logic [7:0] q);
        exp_t x;
        if (!r) begin
            m_busy[d]  = 1'b0;
            m_start[d] = 0;
            m_sel[d]   = 0;
            m_held[d]  = 0;
        end else if (!m_busy[d]) begin
            if (e && q != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int idx;
                    idx = (m_start[d] + k) % 8;
                    if (q[idx] && !m_busy[d]) begin
                        m_busy[d]  = 1'b1;
                        m_owner[d] = idx;
                        m_sel[d]   = idx;
                        m_held[d]  = 1;
                    end
                end
            end
        end else begin
            if (!q[m_owner[d]] || !e || m_held[d] == m_limit[d]) begin
                m_busy[d]  = 1'b0;
                m_start[d] = (m_owner[d] + 1) % 8;
            end else begin
                m_held[d] = m_held[d] + 1;
            end
        end
        x.sel = 3'(m_sel[d]);
        x.gnt = m_busy[d] ? 8'(1 << m_owner[d]) : 8'h00;
        x.vld = m_busy[d];
        if (d == 0) exp_a.push_back(x);
        else        exp_b.push_back(x);
    endtask

    task automatic step(input bit r, input bit e, input logic [7:0] q);
        @(negedge clk);
        rst_n      = r;
        bus_a.en   = e;
        bus_a.req  = q;
        bus_b.en   = e;
        bus_b.req  = q;
        for (int d = 0; d < 2; d++) model_step(d, r, e, q);
    endtask

    task automatic repeat_step(input int n, input bit r, input bit e, input logic [7:0] q);
        for (int i = 0; i < n; i++) step(r, e, q);
    endtask

    // Monitor: compares every registered output one time unit after each rising edge.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_a.size() != 0) begin
                x = exp_a.pop_front();
                check("a_sel", 32'(bus_a.sel), 32'(x.sel));
                check("a_gnt", 32'(bus_a.gnt), 32'(x.gnt));
                check("a_vld", 32'(bus_a.gnt_vld), 32'(x.vld));
                check("a_onehot", 32'(((bus_a.gnt & (bus_a.gnt - 8'd1)) == 8'h00) &&
                                      ((bus_a.gnt != 8'h00) == bus_a.gnt_vld)), 32'd1);
            end
            if (exp_b.size() != 0) begin
                x = exp_b.pop_front();
                check("b_sel", 32'(bus_b.sel), 32'(x.sel));
                check("b_gnt", 32'(bus_b.gnt), 32'(x.gnt));
                check("b_vld", 32'(bus_b.gnt_vld), 32'(x.vld));
                check("b_onehot", 32'(((bus_b.gnt & (bus_b.gnt - 8'd1)) == 8'h00) &&
                                      ((bus_b.gnt != 8'h00) == bus_b.gnt_vld)), 32'd1);
            end
        end
    end

    initial begin : stimulus
        bus_a.en  = 1'b1;
        bus_a.req = 8'hFF;
        bus_b.en  = 1'b1;
        bus_b.req = 8'hFF;

        // Reset held with every request high.
        repeat_step(3, 1'b0, 1'b1, 8'hFF);

        // Single requester 3 held: max-length grants separated by one idle cycle.
        repeat_step(20, 1'b1, 1'b1, 8'h08);

        // Full rotation with every requester asking, including the 7 -> 0 wrap.
        repeat_step(46, 1'b1, 1'b1, 8'hFF);

        // Fairness skip: after requester 0 is served, 5 wins over 0.
        step(1'b0, 1'b1, 8'h00);
        repeat_step(5, 1'b1, 1'b1, 8'h01);
        repeat_step(12, 1'b1, 1'b1, 8'h21);

        // Early release of requester 2 at the second held cycle; the next winner is 3.
        step(1'b0, 1'b1, 8'h00);
        repeat_step(2, 1'b1, 1'b1, 8'h04);
        step(1'b1, 1'b1, 8'h00);
        repeat_step(3, 1'b1, 1'b1, 8'hFF);

        // Disable during the grant to 6; the next winner is 7.
        step(1'b0, 1'b1, 8'h00);
        repeat_step(2, 1'b1, 1'b1, 8'h40);
        repeat_step(2, 1'b1, 1'b0, 8'h40);
        repeat_step(3, 1'b1, 1'b1, 8'hFF);

        // Reset during the grant to 6; the next search starts at 0.
        repeat_step(2, 1'b1, 1'b1, 8'h40);
        step(1'b0, 1'b1, 8'h40);
        repeat_step(3, 1'b1, 1'b1, 8'hFF);

        // Disabled while idle: no grant, and the pointer is kept.
        repeat_step(3, 1'b1, 1'b0, 8'hFF);
        repeat_step(3, 1'b1, 1'b1, 8'hFF);

        // Random traffic with occasional disables and resets.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] q;
            bit r, e;
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 9) != 0);
            q = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) q = bus_a.req;
            step(r, e, q);
        end

        repeat_step(2, 1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #2;
        check("drain", 32'(exp_a.size() + exp_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb8_ctrl.md
RR_ARB8_CTRL -- requirements
Module: rr_arb8_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive cycles one grant may be held; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 en  input  1  arbiter enable; low blocks new grants and terminates any active grant.
REQ-005 req  input  8  request vector; bit k high = requester k wants the shared 3-to-8 decoded resource.
REQ-006 sel  output  3  binary index of the granted requester; drives decoder select input i.
REQ-007 gnt  output  8  one-hot grant; equals decode of sel when gnt_vld=1, else 8'h00.
REQ-008 gnt_vld  output  1  high while a grant is active.
REQ-009 All outputs SHALL be registered; no combinational path from req or en to any output.

Function
REQ-010 FSM SHALL have two states: IDLE (no grant) and GRANT (one requester owns resource).
REQ-011 Internal state: 3-bit priority pointer ptr; 8-bit hold counter hcnt.
REQ-012 IDLE -> GRANT when en=1 and req!=0 at a rising edge; winner = first set bit of req scanning ptr, ptr+1, ..., ptr+7 (mod 8).
REQ-013 Grant latency SHALL be one cycle: req sampled at edge N -> gnt/sel/gnt_vld valid after edge N.
REQ-014 On entering GRANT, hcnt SHALL load 1; each further GRANT cycle increments hcnt.
REQ-015 GRANT -> IDLE at the first edge where any of: req[sel]=0, en=0, or hcnt=MAX_HOLD.
REQ-016 On GRANT -> IDLE, ptr SHALL load sel+1 mod 8 (7 wraps to 0); gnt=0, gnt_vld=0, sel holds last value.
REQ-017 At least one IDLE cycle SHALL separate consecutive grants; no back-to-back handover.
REQ-018 Requests on bits other than sel SHALL be ignored during GRANT; no preemption.
REQ-019 Simultaneous terminating conditions SHALL produce a single release, identical to any one of them.
REQ-020 MAX_HOLD=1 SHALL yield exactly one-cycle grants, each followed by one IDLE cycle.
REQ-021 en=0 in IDLE: remain IDLE, ptr unchanged, regardless of req.
REQ-022 ptr SHALL change only on GRANT -> IDLE transitions and on reset.
REQ-023 gnt SHALL never have more than one bit set; gnt_vld=1 iff gnt!=0.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force: state IDLE, ptr=0, hcnt=0, sel=3'd0, gnt=8'h00, gnt_vld=0.
REQ-025 Reset SHALL take priority over all other conditions, including mid-grant; ptr does not advance on reset.
REQ-026 First arbitration after reset release SHALL start scanning from requester 0.

Verification
REQ-027 Reset: rst_n=0, en=1, req=8'hFF for 3 cycles -> gnt=8'h00, sel=0, gnt_vld=0 throughout.
REQ-028 Single requester: en=1, req=8'h08 held -> one cycle later gnt=8'h08, sel=3; with MAX_HOLD=8, released after 8 cycles, 1 idle cycle, regranted to 3.
REQ-029 Full rotation: MAX_HOLD=4, req=8'hFF constant -> grants to 0,1,...,7,0 in order, each 4 cycles, separated by 1 idle cycle; ptr wraps 7->0.
REQ-030 Fairness skip: after grant to 0 released, req=8'h21 -> next grant sel=5 (not 0); then after release, sel=0.
REQ-031 Early release: grant to 2 active, req[2] drops at hcnt=2 -> gnt=8'h00 next cycle, ptr=3.
REQ-032 Disable and reset mid-grant: en=0 during grant to 6 -> released next cycle, ptr=7; separately rst_n=0 during grant to 6 -> outputs reset, next grant scans from 0.
